// File: rtl/agc_param.sv
// Single-channel automatic gain control: scales a signed stream by a registered
// fixed-point gain, saturates, and adapts the gain with attack/hold/decay dynamics.
module agc_param #(
  parameter int DATA_W       = 8,
  parameter int GAIN_W       = 8,
  parameter int GAIN_FRAC    = 4,
  parameter int ATTACK_SHIFT = 3,
  parameter int DECAY_SHIFT  = 6,
  parameter int HOLD_SAMPLES = 4,
  parameter int HYST         = 8,
  parameter int GAIN_MIN     = 1,
  parameter int GAIN_MAX     = 255
) (
  input  logic                     clk,
  input  logic                     reset_x,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic        [DATA_W-1:0] target,
  input  logic        [1:0]        mode,
  input  logic        [GAIN_W-1:0] manual_gain,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     clip,
  output logic        [GAIN_W-1:0] gain,
  output logic                     hold_active
);

  typedef enum logic [1:0] {
    MODE_AUTO   = 2'b00,
    MODE_FREEZE = 2'b01,
    MODE_MANUAL = 2'b10,
    MODE_BYPASS = 2'b11
  } mode_e;

  typedef enum logic {
    TRACK = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam int PW    = DATA_W + GAIN_W + 1;
  localparam int CNT_W = (HOLD_SAMPLES > 0) ? $clog2(HOLD_SAMPLES + 1) : 1;
  localparam logic signed [PW-1:0] Y_MAX     = PW'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [PW-1:0] Y_MIN     = -Y_MAX - PW'(1);
  localparam logic [CNT_W-1:0]     HOLD_LOAD = CNT_W'(HOLD_SAMPLES);
  localparam logic [GAIN_W-1:0]    GAIN_UNITY = GAIN_W'(1 << GAIN_FRAC);

  function automatic logic [GAIN_W-1:0] clamp_gain(input int v);
    if (v < GAIN_MIN)      return GAIN_W'(GAIN_MIN);
    else if (v > GAIN_MAX) return GAIN_W'(GAIN_MAX);
    else                   return GAIN_W'(v);
  endfunction

  mode_e              mode_q;
  state_e             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [GAIN_W-1:0]  gain_next;
  logic [GAIN_W-1:0]  atk_step, dcy_step;

  logic signed [PW-1:0]     p, y;
  logic signed [DATA_W-1:0] sat;
  logic                     sat_clip;
  logic signed [DATA_W:0]   ext;
  logic        [DATA_W:0]   mag;
  logic                     over, under;

  assign mode_q = mode_e'(mode);

  // Scale, floor-shift and saturate; magnitude is taken on the saturated value.
  always_comb begin
    p        = $signed(in_data) * $signed({1'b0, gain});
    y        = p >>> GAIN_FRAC;
    sat_clip = 1'b0;
    if (y > Y_MAX) begin
      sat      = Y_MAX[DATA_W-1:0];
      sat_clip = 1'b1;
    end else if (y < Y_MIN) begin
      sat      = Y_MIN[DATA_W-1:0];
      sat_clip = 1'b1;
    end else begin
      sat = y[DATA_W-1:0];
    end
    ext   = {sat[DATA_W-1], sat};
    mag   = ext[DATA_W] ? -ext : ext;
    over  = mag > (DATA_W + 1)'(target);
    under = (32'(mag) + 32'(HYST)) < 32'(target);
  end

  assign atk_step = ((gain >> ATTACK_SHIFT) == '0) ? GAIN_W'(1) : (gain >> ATTACK_SHIFT);
  assign dcy_step = ((gain >> DECAY_SHIFT)  == '0) ? GAIN_W'(1) : (gain >> DECAY_SHIFT);

  // State register: gain and hold counter travel with the FSM state.
  always_ff @(posedge clk) begin
    // NOTE: every clocked assignment is non-blocking so all registers see
    // pre-edge values of each other regardless of statement order.
    if (reset_x) begin
      state <= TRACK;
      cnt   <= '0;
      gain  <= GAIN_UNITY;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      gain  <= gain_next;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    state_next = state;
    cnt_next   = cnt;
    gain_next  = gain;
    case (mode_q)
      MODE_AUTO: begin
        if (in_valid) begin
          if (over) begin
            gain_next = clamp_gain(int'(gain) - int'(atk_step));
            if (HOLD_SAMPLES > 0) begin
              state_next = HOLD;
              cnt_next   = HOLD_LOAD;
            end
          end else if (state == HOLD) begin
            // Gain may not rise while holding; only the window runs down.
            if (cnt <= CNT_W'(1)) begin
              cnt_next   = '0;
              state_next = TRACK;
            end else begin
              cnt_next = cnt - CNT_W'(1);
            end
          end else if (under) begin
            gain_next = clamp_gain(int'(gain) + int'(dcy_step));
          end
        end
      end
      MODE_FREEZE: ;
      MODE_MANUAL: begin
        gain_next  = clamp_gain(int'(manual_gain));
        state_next = TRACK;
        cnt_next   = '0;
      end
      MODE_BYPASS: begin
        state_next = TRACK;
        cnt_next   = '0;
      end
      default: ;
    endcase
  end

  // Output logic.
  always_comb begin
    hold_active = (state == HOLD);
  end

  // Output sample register; data and clip hold across idle cycles.
  always_ff @(posedge clk) begin
    if (reset_x) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      clip      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        if (mode_q == MODE_BYPASS) begin
          out_data <= in_data;
          clip     <= 1'b0;
        end else begin
          out_data <= sat;
          clip     <= sat_clip;
        end
      end
    end
  end

endmodule

// File: tb/tb_agc_param.sv
// Bench for agc_param: directed vector table, reset corner sequences, and
// randomized traffic against an arithmetic reference model.
module tb_agc_param;

  logic              clk = 1'b0;
  logic              reset_x;
  logic              in_valid;
  logic signed [7:0] in_data;
  logic        [7:0] target;
  logic        [1:0] mode;
  logic        [7:0] manual_gain;
  logic              out_valid;
  logic signed [7:0] out_data;
  logic              clip;
  logic        [7:0] gain;
  logic              hold_active;

  int n_cmp = 0;
  int n_err = 0;

  agc_param dut (
    .clk         (clk),
    .reset_x     (reset_x),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .target      (target),
    .mode        (mode),
    .manual_gain (manual_gain),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .clip        (clip),
    .gain        (gain),
    .hold_active (hold_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input logic rst, input logic v, input int d, input int t,
                      input logic [1:0] md, input int mg);
    reset_x     = rst;
    in_valid    = v;
    in_data     = 8'(d);
    target      = 8'(t);
    mode        = md;
    manual_gain = 8'(mg);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int ev, input int eout,
                           input int eclip, input int egain, input int ehold);
    check({tag, " out_valid"},   int'(out_valid),   ev);
    check({tag, " out_data"},    int'(out_data),    eout);
    check({tag, " clip"},        int'(clip),        eclip);
    check({tag, " gain"},        int'(gain),        egain);
    check({tag, " hold_active"}, int'(hold_active), ehold);
  endtask

  // Reference model: plain integer arithmetic with a "samples of hold left" count.
  int m_valid, m_out, m_clip, m_gain, m_hold_left;

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_clock(input bit rst, input bit v, input int d, input int t,
                             input int md, input int mg);
    int y, mag;
    if (rst) begin
      m_valid = 0; m_out = 0; m_clip = 0; m_gain = 16; m_hold_left = 0;
      return;
    end
    m_valid = v;
    mag = 0;
    if (v) begin
      if (md == 3) begin
        m_out = d; m_clip = 0;
      end else begin
        y = floor_div(d * m_gain, 16);
        m_clip = (y > 127 || y < -128) ? 1 : 0;
        m_out = min_i(127, max_i(-128, y));
      end
      mag = (m_out < 0) ? -m_out : m_out;
    end
    case (md)
      0: if (v) begin
        if (mag > t) begin
          m_gain = max_i(1, m_gain - max_i(m_gain / 8, 1));
          m_hold_left = 4;
        end else if (m_hold_left > 0) begin
          m_hold_left--;
        end else if (mag + 8 < t) begin
          m_gain = min_i(255, m_gain + max_i(m_gain / 64, 1));
        end
      end
      2: begin
        m_gain = min_i(255, max_i(1, mg));
        m_hold_left = 0;
      end
      3: m_hold_left = 0;
      default: ;
    endcase
  endtask

  typedef struct {
    logic [1:0] md;
    int         mg;
    int         tgt;
    logic       v;
    int         din;
    int         eout;
    int         eclip;
    int         egain;
    int         ehold;
    int         ev;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int rnd_mode;
    bit rst_r, v_r;
    int d_r, t_r, md_r, mg_r;

    // Directed table, starting from reset state (gain 16, TRACK).
    vecs.push_back('{2'd0,   0, 100, 1'b1,   50,   50, 0,  17, 0, 1}); // decay
    vecs.push_back('{2'd0,   0, 100, 1'b1,   95,  100, 0,  17, 0, 1}); // in hysteresis band
    vecs.push_back('{2'd2,  16, 100, 1'b0,    0,  100, 0,  16, 0, 0}); // reload gain 16
    vecs.push_back('{2'd0,   0, 100, 1'b1,  120,  120, 0,  14, 1, 1}); // attack
    vecs.push_back('{2'd0,   0, 100, 1'b1,  120,  105, 0,  13, 1, 1}); // re-attack in hold
    vecs.push_back('{2'd0,   0, 100, 1'b1,   10,    8, 0,  13, 1, 1});
    vecs.push_back('{2'd0,   0, 100, 1'b1,   10,    8, 0,  13, 1, 1});
    vecs.push_back('{2'd0,   0, 100, 1'b1,   10,    8, 0,  13, 1, 1});
    vecs.push_back('{2'd0,   0, 100, 1'b1,   10,    8, 0,  13, 0, 1}); // hold expires
    vecs.push_back('{2'd0,   0, 100, 1'b1,   10,    8, 0,  14, 0, 1}); // decay resumes
    vecs.push_back('{2'd0,   0, 100, 1'b0,    0,    8, 0,  14, 0, 0}); // idle
    vecs.push_back('{2'd0,   0, 100, 1'b1,  120,  105, 0,  13, 1, 1});
    vecs.push_back('{2'd1,   0, 100, 1'b1,  120,   97, 0,  13, 1, 1}); // freeze
    vecs.push_back('{2'd1,   0, 100, 1'b1,   10,    8, 0,  13, 1, 1});
    vecs.push_back('{2'd3,   0, 100, 1'b1,   -7,   -7, 0,  13, 0, 1}); // bypass
    vecs.push_back('{2'd0,   0, 100, 1'b1,   -7,   -6, 0,  14, 0, 1}); // back to auto
    vecs.push_back('{2'd2,  32, 100, 1'b0,    0,   -6, 0,  32, 0, 0});
    vecs.push_back('{2'd2,  32, 100, 1'b1,  100,  127, 1,  32, 0, 1}); // saturate high
    vecs.push_back('{2'd2,  32, 100, 1'b1, -100, -128, 1,  32, 0, 1}); // saturate low
    vecs.push_back('{2'd2,  32, 100, 1'b1,  -64, -128, 0,  32, 0, 1}); // exact limit
    vecs.push_back('{2'd2,   0, 100, 1'b0,    0, -128, 0,   1, 0, 0}); // clamp to min
    vecs.push_back('{2'd2, 255, 100, 1'b0,    0, -128, 0, 255, 0, 0});
    vecs.push_back('{2'd0,   0, 127, 1'b1,    1,   15, 0, 255, 0, 1}); // clamp at max
    vecs.push_back('{2'd0,   0, 127, 1'b1,    1,   15, 0, 255, 0, 1});
    vecs.push_back('{2'd0,   0, 127, 1'b1,    1,   15, 0, 255, 0, 1});
    vecs.push_back('{2'd0,   0, 127, 1'b1,   -1,  -16, 0, 255, 0, 1}); // floor of negative

    // Reset held two cycles with a live sample on the input.
    tick(1'b1, 1'b1, 100, 100, 2'd0, 0);
    check_all("reset1", 0, 0, 0, 16, 0);
    tick(1'b1, 1'b1, 100, 100, 2'd0, 0);
    check_all("reset2", 0, 0, 0, 16, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      tick(1'b0, vecs[i].v, vecs[i].din, vecs[i].tgt, vecs[i].md, vecs[i].mg);
      check_all($sformatf("row%0d", i), vecs[i].ev, vecs[i].eout, vecs[i].eclip,
                vecs[i].egain, vecs[i].ehold);
    end

    // Reset landing right after an accepted, attacking sample.
    tick(1'b0, 1'b1, 120, 10, 2'd0, 0);
    check_all("preflight", 1, 127, 1, 224, 1);
    tick(1'b1, 1'b1, 120, 10, 2'd0, 0);
    check_all("midreset", 0, 0, 0, 16, 0);
    tick(1'b0, 1'b1, 120, 100, 2'd0, 0);
    check_all("postreset", 1, 120, 0, 14, 1);

    // Randomized traffic against the reference model.
    tick(1'b1, 1'b0, 0, 0, 2'd0, 0);
    model_clock(1'b1, 1'b0, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      rst_r = ($urandom_range(0, 199) == 0);
      v_r   = ($urandom_range(0, 3) != 0);
      d_r   = int'($urandom_range(0, 255)) - 128;
      t_r   = $urandom_range(0, 255);
      rnd_mode = $urandom_range(0, 15);
      md_r  = (rnd_mode < 10) ? 0 : (rnd_mode < 12) ? 1 : (rnd_mode < 14) ? 2 : 3;
      mg_r  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 255);
      tick(rst_r, v_r, d_r, t_r, 2'(md_r), mg_r);
      model_clock(rst_r, v_r, d_r, t_r, md_r, mg_r);
      check_all($sformatf("rand%0d", n), m_valid, m_out, m_clip, m_gain,
                (m_hold_left > 0) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
